// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the operand loader that feeds it.
package alu_pkg;

    localparam int ALU_W  = 8;
    localparam int RES_W  = 16;
    localparam int WAIT_W = 4;    // holds ALU_LATENCY values up to 15

    typedef enum logic [2:0] {
        ST_LOAD_X  = 3'd0,
        ST_LOAD_Y  = 3'd1,
        ST_LOAD_OP = 3'd2,
        ST_RUN     = 3'd3,
        ST_SHOW    = 3'd4
    } state_e;

    localparam logic [2:0] OP_CLR = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MSB = 3'b111;

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each accepted press (release is silent).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_evt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_evt;

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_evt   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_key};
            r_evt  <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // Level has differed long enough; only the 0->1 flip is an event.
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_evt   <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_evt = r_evt;

endmodule

// File: rtl/alu_operand_loader.sv
// Steps X, Y and S/cin from the switch bank into the ALU, waits out its
// latency and captures the answer with a validity flag.
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_LATENCY     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ALU_W-1:0] i_sw,
    input  logic             i_key_next,
    input  logic             i_key_clr,
    input  logic [RES_W-1:0] i_alu_ans,
    output logic [ALU_W-1:0] o_x,
    output logic [ALU_W-1:0] o_y,
    output logic [2:0]       o_s,
    output logic             o_cin,
    output logic [RES_W-1:0] o_result,
    output logic             o_result_valid,
    output logic [2:0]       o_phase
);

    logic w_next_evt;
    logic w_clr_evt;

    state_e            r_state;
    logic [ALU_W-1:0]  r_x;
    logic [ALU_W-1:0]  r_y;
    logic [2:0]        r_s;
    logic              r_cin;
    logic [RES_W-1:0]  r_result;
    logic              r_result_valid;
    logic [WAIT_W-1:0] r_wait;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_key (i_key_next),
        .o_evt (w_next_evt)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_key (i_key_clr),
        .o_evt (w_clr_evt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_LOAD_X;
            r_x            <= '0;
            r_y            <= '0;
            r_s            <= '0;
            r_cin          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wait         <= '0;
        end else if (w_clr_evt) begin
            // Clear is tested ahead of the state case so it beats a same-cycle next.
            r_state        <= ST_LOAD_X;
            r_x            <= '0;
            r_y            <= '0;
            r_s            <= '0;
            r_cin          <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wait         <= '0;
        end else begin
            case (r_state)
                ST_LOAD_X: if (w_next_evt) begin
                    r_x     <= i_sw;
                    r_state <= ST_LOAD_Y;
                end
                ST_LOAD_Y: if (w_next_evt) begin
                    r_y     <= i_sw;
                    r_state <= ST_LOAD_OP;
                end
                ST_LOAD_OP: if (w_next_evt) begin
                    r_s     <= i_sw[2:0];
                    r_cin   <= i_sw[3];
                    r_wait  <= '0;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Presses are deliberately ignored until the answer is captured.
                    if (r_wait == WAIT_W'(ALU_LATENCY)) begin
                        r_result       <= i_alu_ans;
                        r_result_valid <= 1'b1;
                        r_state        <= ST_SHOW;
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                ST_SHOW: if (w_next_evt) begin
                    r_result_valid <= 1'b0;
                    r_state        <= ST_LOAD_X;
                end
                default: r_state <= ST_LOAD_X;
            endcase
        end
    end

    assign o_x            = r_x;
    assign o_y            = r_y;
    assign o_s            = r_s;
    assign o_cin          = r_cin;
    assign o_result       = r_result;
    assign o_result_valid = r_result_valid;
    assign o_phase        = r_state;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

- Upstream front end for the 8-bit ALU.
- Loads X, Y and the operation select (S, cin) from eight board switches, one debounced push-button press per step.
- Holds those operands stable on the ALU inputs, waits the ALU's registered latency, then captures its 16-bit answer into a display-ready result register.
- The ALU has no reset and no valid flag, so this block owns sequencing and result validity.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz; 4 in simulation).
- ALU_LATENCY, 1, clock edges from operands changing to the ALU's ans being updated.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  8  raw switch bank; treated as quasi-static and sampled only on an accepted press.
- key_next  in  1  raw "next step" button, active-high, bouncy.
- key_clr  in  1  raw "clear" button, active-high, bouncy.
- alu_ans  in  16  ALU result.
- X  out  8  ALU operand X.
- Y  out  8  ALU operand Y.
- S  out  3  ALU operation select.
- cin  out  1  ALU carry-in.
- result  out  16  captured ALU answer.
- result_valid  out  1  high while result holds the answer for the current X/Y/S/cin.
- phase  out  3  current state code, for LEDs.

## Operation
- **Key conditioning (per button)**
  - 2-flop synchronizer feeds a stability counter.
  - The counter clears whenever the synchronized level equals the debounced level.
  - When the levels have differed for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips.
  - A rising edge of the debounced level produces a one-cycle event pulse (next_evt / clr_evt).
  - Release produces no event. A held key produces exactly one event.
- **FSM states** (phase code in brackets):
  - LOAD_X (0): on next_evt, X <= sw; go to LOAD_Y.
  - LOAD_Y (1): on next_evt, Y <= sw; go to LOAD_OP.
  - LOAD_OP (2): on next_evt, S <= sw[2:0], cin <= sw[3], wait counter <= 0; go to RUN. sw[7:4] is ignored.
  - RUN (3): counter increments each cycle. When it reaches ALU_LATENCY, result <= alu_ans and result_valid <= 1; go to SHOW. next_evt is dropped in this state.
  - SHOW (4): on next_evt, result_valid <= 0; go to LOAD_X. X, Y, S and cin keep their values until overwritten.
- **Clear**
  - clr_evt in any state: X, Y, S, cin, result <= 0; result_valid <= 0; go to LOAD_X.
  - If clr_evt and next_evt occur in the same cycle, clear wins.
- **Operand stability**
  - X, Y, S and cin change only on the accepted-press edges above, or on clear/reset.
  - result never changes except on capture, clear or reset.
- **Widths**
  - result is a straight 16-bit copy of alu_ans; no arithmetic is done here.
  - The wait counter is wide enough for ALU_LATENCY up to 15.
- **Reset** (asynchronous, any time, including mid-RUN):
  - All outputs go to 0; phase = LOAD_X.
  - Debounced levels go to 0 and counters go to 0. No event is generated by reset release.
  - A button already held at reset release produces one event after the debounce time.

## Timing
- Call E0 the edge at which S/cin load in LOAD_OP.
  - The ALU samples the new operands at E1.
  - result and result_valid update at edge E0+ALU_LATENCY+1, i.e. E2 for the default.
- Button event:
  - next_evt asserts within DEBOUNCE_CYCLES+3 edges of a clean raw rise.
  - The FSM acts on the edge where next_evt is high.
- The FSM advances at most one state per accepted press.
- No combinational path from any input to any output; every output is a register.

## Structure
- Shared package alu_pkg holds:
  - the state enum with its codes (LOAD_X=0 … SHOW=4);
  - the ALU opcode constants for S (OP_CLR=000, OP_AND=001, OP_OR=010, OP_XOR=011, OP_ADD=100, OP_SHL=101, OP_SHR=110, OP_MSB=111);
  - ALU_W=8 and RES_W=16.
- One sub-module, key_debounce (synchronizer, stability counter, rising-edge pulse), is instantiated twice.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and a bench ALU model with ALU_LATENCY=1.
- **Add with carry:** load sw=0x5A, then 0x3C, then 0x0C; bench ALU returns 0x0097 → X=0x5A, Y=0x3C, S=3'b100, cin=1; result=0x0097 with result_valid rising exactly 2 edges after the S load; phase=4.
- **Debounce:** key_next toggles every 2 cycles for 12 cycles, then holds high for 40 cycles → exactly one next_evt; phase advances 0→1 only.
- **Press during RUN:** with ALU_LATENCY=3, press during RUN → press ignored; result captured at E0+4; phase=4. The next press returns phase to 0 with result_valid=0 and X still 0x5A.
- **Clear vs next:** in LOAD_Y, key_clr and key_next rise together → X=Y=S=cin=0, result=0, phase=0.
- **Reset mid-operation:** assert rst during RUN → all outputs 0 immediately; phase=0. With key_next held through reset release → exactly one event, X loads sw.
- **Zero op:** sw=0x00 loaded for S, ALU returns 0x0000 → result=0x0000 with result_valid=1, confirming validity does not depend on a nonzero result.
